// File: rtl/square_root_module_pkg.sv
// Shared constants and types for the fixed-point square-root unit.
//
// LAMP_FLOAT_F_DW  fraction width of the lampFPU single-precision format
// SQRT_N           operand width (hidden bit + fraction), must be even
// SQRT_ITER        number of recurrence iterations = significant root bits
// SQRT_RAD_W       radicand shift-register width ({s, 2N zeros})
// SQRT_REM_W       partial-remainder width, wide enough for {rem, 2 bits}
// SQRT_CNT_W       iteration counter width
// sqrt_state_e     control FSM states
package square_root_module_pkg;

  localparam int unsigned LAMP_FLOAT_F_DW = 7;
  localparam int unsigned SQRT_N          = 1 + LAMP_FLOAT_F_DW;
  localparam int unsigned SQRT_ITER       = 3 * SQRT_N / 2;
  localparam int unsigned SQRT_RAD_W      = 3 * SQRT_N;
  localparam int unsigned SQRT_REM_W      = SQRT_ITER + 3;
  localparam int unsigned SQRT_CNT_W      = $clog2(SQRT_ITER + 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } sqrt_state_e;

endpackage

// File: rtl/square_root_module_if.sv
// Start/valid handshake bundle for the square-root unit.
//
// doSqrt_i  requester -> unit  start request, level-sampled while idle
// s_i       requester -> unit  N-bit unsigned radicand
// res_o     unit -> requester  2N-bit root in Q(N).(N)
// valid_o   unit -> requester  one-cycle result strobe
//
// master: requester side, slave: square-root unit side.
interface square_root_module_if #(
  parameter int unsigned N = 8
) ();

  logic             doSqrt_i;
  logic [N-1:0]     s_i;
  logic [2*N-1:0]   res_o;
  logic             valid_o;

  modport master (
    output doSqrt_i,
    output s_i,
    input  res_o,
    input  valid_o
  );

  modport slave (
    input  doSqrt_i,
    input  s_i,
    output res_o,
    output valid_o
  );

endinterface

// File: rtl/square_root_module_iter_stage.sv
// One step of the radix-2 restoring square-root recurrence (purely combinational).
//
// rem_i   partial remainder in
// root_i  partial root in
// bits_i  next two radicand bits (MSB first)
// rem_o   updated partial remainder
// root_o  partial root with the new digit appended
//
// RemW must be at least RootW + 3 so that {rem, bits} never overflows.
module square_root_module_iter_stage #(
  parameter int unsigned RemW  = 15,
  parameter int unsigned RootW = 12
) (
  input  logic [RemW-1:0]  rem_i,
  input  logic [RootW-1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [RemW-1:0]  rem_o,
  output logic [RootW-1:0] root_o
);

  logic [RemW-1:0] rem_sh;
  logic [RemW-1:0] trial_sub;

  // The remainder is bounded by 2*root, so dropping its top bits on the shift is lossless.
  assign rem_sh    = RemW'({rem_i, bits_i});
  assign trial_sub = RemW'({root_i, 2'b01});

  always_comb begin
    rem_o  = rem_sh;
    root_o = RootW'({root_i, 1'b0});
    if (rem_sh >= trial_sub) begin
      rem_o  = rem_sh - trial_sub;
      root_o = RootW'({root_i, 1'b1});
    end
  end

endmodule

// File: rtl/square_root_module.sv
// Multi-cycle unsigned fixed-point square root for the lampFPU sqrt datapath.
// Computes res_o = floor(sqrt(s_i * 2^(2N))), i.e. sqrt(s_i) with N integer and
// N fraction bits, one root bit per cycle (SQRT_ITER cycles per operation).
//
// clk       clock, rising edge
// rst       synchronous active-high reset
// sqrt_bus  slave side of square_root_module_if (doSqrt_i, s_i, res_o, valid_o)
//
// Optional build macro SQRT_MODULE_ZERO_BYPASS_EN: a zero radicand skips the
// recurrence and completes on the cycle after the start edge.
module square_root_module
  import square_root_module_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  square_root_module_if.slave  sqrt_bus
);

  sqrt_state_e              state_q, state_d;
  logic [SQRT_RAD_W-1:0]    rad_q, rad_d;
  logic [SQRT_REM_W-1:0]    rem_q, rem_d;
  logic [SQRT_ITER-1:0]     root_q, root_d;
  logic [SQRT_CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*SQRT_N-1:0]      res_q, res_d;

  logic [SQRT_REM_W-1:0]    rem_nxt;
  logic [SQRT_ITER-1:0]     root_nxt;

  square_root_module_iter_stage #(
    .RemW  (SQRT_REM_W),
    .RootW (SQRT_ITER)
  ) u_iter_stage (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[SQRT_RAD_W-1 -: 2]),
    .rem_o  (rem_nxt),
    .root_o (root_nxt)
  );

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    unique case (state_q)
      StIdle: begin
        if (sqrt_bus.doSqrt_i) begin
          rad_d  = {sqrt_bus.s_i, {(2 * SQRT_N){1'b0}}};
          rem_d  = '0;
          root_d = '0;
          cnt_d  = '0;
`ifdef SQRT_MODULE_ZERO_BYPASS_EN
          if (sqrt_bus.s_i == '0) begin
            state_d = StDone;
            res_d   = '0;
          end else begin
            state_d = StBusy;
          end
`else
          state_d = StBusy;
`endif
        end
      end

      StBusy: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_nxt;
        root_d = root_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SQRT_CNT_W'(SQRT_ITER - 1)) begin
          state_d = StDone;
          res_d   = (2 * SQRT_N)'(root_nxt);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign sqrt_bus.res_o   = res_q;
  assign sqrt_bus.valid_o = (state_q == StDone);

endmodule

// File: tb/tb_square_root_module.sv
// Self-checking bench for square_root_module: a cycle-timeline reference model
// checked every cycle, plus directed literal checks of results and latency.
module tb_square_root_module;

  localparam int N    = 8;
  localparam int ITER = 12;

  logic clk_tb = 1'b0;
  logic rst;

  always #5 clk_tb = ~clk_tb;

  square_root_module_if #(.N(N)) bus ();

  square_root_module dut (
    .clk      (clk_tb),
    .rst      (rst),
    .sqrt_bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: largest r with r*r <= s * 2^16.
  function automatic logic [2*N-1:0] ref_sqrt(input logic [N-1:0] s);
    longint v;
    longint r;
    v = longint'(s) * 65536;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return (2*N)'(r);
  endfunction

  // Negedges from the start edge until valid_o is seen.
  function automatic int lat_for(input logic [N-1:0] s);
`ifdef SQRT_MODULE_ZERO_BYPASS_EN
    if (s == '0) return 1;
`endif
    return ITER + 1;
  endfunction

  // Timeline model: an operation accepted while idle completes a fixed number of
  // edges later, then one edge of cool-down ignores requests.
  bit              model_on = 1'b0;
  bit              busy     = 1'b0;
  bit              cool     = 1'b0;
  int              remaining;
  logic [2*N-1:0]  pend;
  logic [2*N-1:0]  exp_res  = '0;
  logic            exp_valid = 1'b0;

  always @(posedge clk_tb) begin
    if (rst) begin
      model_on  = 1'b1;
      busy      = 1'b0;
      cool      = 1'b0;
      exp_res   = '0;
      exp_valid = 1'b0;
    end else if (model_on) begin
      exp_valid = 1'b0;
      if (busy) begin
        remaining--;
        if (remaining == 0) begin
          exp_res   = pend;
          exp_valid = 1'b1;
          busy      = 1'b0;
          cool      = 1'b1;
        end
      end else if (cool) begin
        cool = 1'b0;
      end else if (bus.doSqrt_i) begin
        pend      = ref_sqrt(bus.s_i);
        remaining = lat_for(bus.s_i) - 1;
        if (remaining == 0) begin
          exp_res   = pend;
          exp_valid = 1'b1;
          cool      = 1'b1;
        end else begin
          busy = 1'b1;
        end
      end
    end
  end

  always @(negedge clk_tb) begin
    if (model_on) begin
      checks++;
      if (bus.valid_o !== exp_valid || bus.res_o !== exp_res) begin
        errors++;
        $display("FAIL model t=%0t: valid_o=%0b res_o=%0d, required valid_o=%0b res_o=%0d",
                 $time, bus.valid_o, bus.res_o, exp_valid, exp_res);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
  task automatic run_op(input logic [N-1:0] s, input logic [2*N-1:0] req, input string name);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    bus.s_i      = s;
    bus.doSqrt_i = 1'b1;
    while (n < 40 && !got) begin
      @(negedge clk_tb);
      n++;
      if (bus.valid_o) got = 1'b1;
      if (n == 3) bus.s_i = ~s;
    end
    bus.doSqrt_i = 1'b0;
    check({name, " latency"}, got ? n : -1, lat_for(s));
    check({name, " res"}, bus.res_o, req);
    @(negedge clk_tb);
    check({name, " valid width"}, bus.valid_o, 0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk_tb);
      n++;
    end while (n < 40 && !bus.valid_o);
    if (!bus.valid_o) n = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n1, n2;
    rst          = 1'b1;
    bus.doSqrt_i = 1'b0;
    bus.s_i      = '0;
    repeat (2) @(negedge clk_tb);
    check("reset valid_o", bus.valid_o, 0);
    check("reset res_o", bus.res_o, 0);
    rst = 1'b0;
    @(negedge clk_tb);

    // Directed literals pin both the DUT and the reference model.
    check("model 25", ref_sqrt(8'd25), 1280);
    run_op(8'd25, 16'd1280, "s=25");
    run_op(8'd1, 16'd256, "s=1");
    run_op(8'd64, 16'd2048, "s=64");
    run_op(8'd2, 16'd362, "s=2");
    run_op(8'd255, 16'd4087, "s=255");
    run_op(8'd0, 16'd0, "s=0");

    // Back-to-back with doSqrt_i held high; s_i wiggles while busy.
    bus.s_i      = 8'd25;
    bus.doSqrt_i = 1'b1;
    @(negedge clk_tb);
    bus.s_i = 8'hA5;
    wait_valid(n1);
    check("b2b first latency", n1, ITER);
    check("b2b first res", bus.res_o, 1280);
    bus.s_i = 8'd255;
    @(negedge clk_tb);
    @(negedge clk_tb);
    bus.s_i = 8'h3C;
    wait_valid(n2);
    check("b2b spacing", (n2 < 0) ? -1 : n2 + 2, 14);
    check("b2b second res", bus.res_o, 4087);
    bus.doSqrt_i = 1'b0;
    repeat (2) @(negedge clk_tb);

    // Reset mid-operation aborts it.
    bus.s_i      = 8'd200;
    bus.doSqrt_i = 1'b1;
    repeat (5) @(negedge clk_tb);
    bus.doSqrt_i = 1'b0;
    rst          = 1'b1;
    @(negedge clk_tb);
    check("abort valid_o", bus.valid_o, 0);
    check("abort res_o", bus.res_o, 0);
    rst = 1'b0;
    repeat (16) begin
      @(negedge clk_tb);
      check("abort no valid", bus.valid_o, 0);
    end
    run_op(8'd64, 16'd2048, "after abort s=64");

    // Exhaustive sweep against the reference model.
    for (int s = 0; s < 256; s++) run_op(8'(s), ref_sqrt(8'(s)), "sweep");

    // Random requests, radicand churn and occasional resets; model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_tb);
      rst          = ($urandom_range(0, 199) == 0);
      bus.doSqrt_i = ($urandom_range(0, 2) == 0);
      bus.s_i      = 8'($urandom);
    end
    rst          = 1'b0;
    bus.doSqrt_i = 1'b0;
    repeat (20) @(negedge clk_tb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
